id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register of the 5-stage RISC-V core, with integrated load-use interlock. Captures decode-stage operands, register indices and control each cycle and presents them as E-stage signals (`rs1_e`, `rs2_e`, `rd_e`, `regwrite_e`, …). These feed the forwarding hazard unit and the execute datapath. Inserts a bubble on load-use dependency or on taken-branch/jump flush, and drives the fetch/decode stall.

## Interface
- `XLEN`, 32: datapath width.
- `ALUCTL_W`, 3: ALU control width.
- `clk` input 1: core clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pc_d`, `pc_plus4_d`, `rd1_d`, `rd2_d`, `immext_d` input XLEN each: decode-stage values.
- `rs1_d`, `rs2_d`, `rd_d` input 5 each: decode register indices.
- `regwrite_d`, `memwrite_d`, `jump_d`, `branch_d`, `alusrc_d` input 1 each: decode control.
- `resultsrc_d` input 2: 00 ALU, 01 load, 10 PC+4.
- `alucontrol_d` input ALUCTL_W: ALU operation.
- `flush_e` input 1: taken branch/jump resolved in E; squash incoming instruction.
- E-stage registered copies of every decode input above, with suffix `_e`, same widths.
- `valid_e` output 1: E holds a real instruction (0 = bubble).
- `stall_fd` output 1: hold PC and IF/ID register this cycle (combinational).

## Operation
- Load-use detect, combinational: `lu = valid_e & (resultsrc_e==01) & (rd_e!=0) & ((rd_e==rs1_d) | (rd_e==rs2_d))`.
- `stall_fd = lu & ~flush_e`.
- Register update priority on each rising edge:
  - `flush_e`: load a bubble.
  - Else `lu`: load a bubble. Decode is held upstream, so the same instruction is re-presented next cycle.
  - Else: capture all `_d` inputs; `valid_e`=1.
- Bubble: all `_e` outputs are 0; `valid_e`=0. A bubble with `regwrite_e=0` and `memwrite_e=0` is architecturally a NOP.
- States are implicit: NORMAL (capture) and BUBBLE (one inserted cycle).
  - A load-use dependency yields exactly one bubble. The next cycle `valid_e`=0, so `lu`=0 and the held instruction is captured.
  - Back-to-back load → dependent → dependent gives one bubble only. After the bubble the load is in M and is forwarded by the hazard unit.
- `flush_e` together with `lu`: bubble inserted; `stall_fd` is forced low so fetch takes the redirect.
- Source index x0 never creates a dependency, because the `rd_e!=0` term excludes it.

## Timing
- Latency: 1 cycle, D inputs to E outputs.
- `stall_fd` is purely combinational from E register contents, `*_d` inputs and `flush_e`. There is no registered delay and no dependency on `clk` phase.
- Reset (`rst_n`=0, asynchronous): every `_e` output, including `valid_e`, is 0 immediately. `stall_fd` is 0 because `valid_e`=0.
- Reset deassertion mid-pipeline: the first edge after release captures D normally.
- Reset asserted mid-bubble: the bubble is discarded; no pending stall survives reset.

## Configuration
- `IDEX_X0_GUARD_EN` defined: if `rd_d==0`, the captured `regwrite_e` is forced to 0 and `rd_e` stays 0. Downstream forwarding therefore never matches x0.
- `IDEX_X0_GUARD_EN` undefined: `regwrite_d` and `rd_d` are captured unmodified. Load-use detection still excludes `rd_e==0` in both builds.

## Structure
- Shared package `core_pkg`:
  - `XLEN`.
  - `resultsrc` encodings `RES_ALU=2'b00`, `RES_LOAD=2'b01`, `RES_PC4=2'b10`.
  - Packed struct `ctrl_t` {regwrite, resultsrc, memwrite, jump, branch, alucontrol, alusrc}.
  - Bubble constant `CTRL_NOP` (all zero).
- One sub-module, `load_use_detect`: purely combinational `lu` / `stall_fd` logic. The register bank stays in `id_ex_stage`.

## Test plan
- Reset: drive all `_d` inputs nonzero, pulse `rst_n` low between edges → all `_e` outputs and `valid_e` go to 0 immediately; `stall_fd`=0.
- Normal capture: `rd_d`=5, `rs1_d`=3, `regwrite_d`=1, `immext_d`=0x10 → on the next edge `rd_e`=5, `rs1_e`=3, `regwrite_e`=1, `immext_e`=0x10, `valid_e`=1.
- Load-use on rs2: E holds a load with `rd_e`=7; D has `rs2_d`=7 → `stall_fd`=1 that cycle. The next edge gives a bubble (`valid_e`=0). With D held, the following edge captures the instruction with `stall_fd`=0.
- Load to x0: E holds a load with `rd_e`=0; D has `rs1_d`=0 → `stall_fd`=0; no bubble.
- Flush with load-use: the conditions of the load-use rs2 scenario plus `flush_e`=1 → `stall_fd`=0 and a bubble on the next edge.
- Guard macro: `rd_d`=0, `regwrite_d`=1.
  - With `IDEX_X0_GUARD_EN` defined → `regwrite_e`=0.
  - Without it → `regwrite_e`=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, result-source encodings and the
// decode control bundle carried down the pipeline.
package core_pkg;

  localparam int XLEN     = 32;
  localparam int ALUCTL_W = 3;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  typedef struct packed {
    logic                regwrite;
    logic [1:0]          resultsrc;
    logic                memwrite;
    logic                jump;
    logic                branch;
    logic [ALUCTL_W-1:0] alucontrol;
    logic                alusrc;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use interlock: flags a decode instruction that reads the
// destination of a load currently in E, and derives the fetch/decode stall.
module load_use_detect
  import core_pkg::*;
(
  input  logic       i_valid_e,
  input  logic [1:0] i_resultsrc_e,
  input  logic [4:0] i_rd_e,
  input  logic [4:0] i_rs1_d,
  input  logic [4:0] i_rs2_d,
  input  logic       i_flush_e,
  output logic       o_lu,
  output logic       o_stall_fd
);

  logic w_is_load;
  logic w_src_match;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign w_is_load   = i_valid_e & (i_resultsrc_e == RES_LOAD) & (i_rd_e != 5'd0);
  assign w_src_match = (i_rd_e == i_rs1_d) | (i_rd_e == i_rs2_d);

  assign o_lu = w_is_load & w_src_match;

  // A flush redirects fetch, so stalling would only swallow the redirect.
  assign o_stall_fd = o_lu & ~i_flush_e;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and flush squash.
// Optional build macro IDEX_X0_GUARD_EN: never mark a write to x0 as a regwrite.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN     = core_pkg::XLEN,
  parameter int ALUCTL_W = core_pkg::ALUCTL_W
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic [XLEN-1:0]     pc_d,
  input  logic [XLEN-1:0]     pc_plus4_d,
  input  logic [XLEN-1:0]     rd1_d,
  input  logic [XLEN-1:0]     rd2_d,
  input  logic [XLEN-1:0]     immext_d,
  input  logic [4:0]          rs1_d,
  input  logic [4:0]          rs2_d,
  input  logic [4:0]          rd_d,
  input  logic                regwrite_d,
  input  logic                memwrite_d,
  input  logic                jump_d,
  input  logic                branch_d,
  input  logic                alusrc_d,
  input  logic [1:0]          resultsrc_d,
  input  logic [ALUCTL_W-1:0] alucontrol_d,
  input  logic                flush_e,

  output logic [XLEN-1:0]     pc_e,
  output logic [XLEN-1:0]     pc_plus4_e,
  output logic [XLEN-1:0]     rd1_e,
  output logic [XLEN-1:0]     rd2_e,
  output logic [XLEN-1:0]     immext_e,
  output logic [4:0]          rs1_e,
  output logic [4:0]          rs2_e,
  output logic [4:0]          rd_e,
  output logic                regwrite_e,
  output logic                memwrite_e,
  output logic                jump_e,
  output logic                branch_e,
  output logic                alusrc_e,
  output logic [1:0]          resultsrc_e,
  output logic [ALUCTL_W-1:0] alucontrol_e,
  output logic                valid_e,
  output logic                stall_fd
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic [XLEN-1:0] r_rd1;
  logic [XLEN-1:0] r_rd2;
  logic [XLEN-1:0] r_immext;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  ctrl_t           r_ctrl;
  logic            r_valid;

  ctrl_t           w_ctrl_d;
  logic            w_lu;
  logic            w_bubble;

  always_comb begin
    w_ctrl_d            = CTRL_NOP;
    w_ctrl_d.regwrite   = regwrite_d;
    w_ctrl_d.resultsrc  = resultsrc_d;
    w_ctrl_d.memwrite   = memwrite_d;
    w_ctrl_d.jump       = jump_d;
    w_ctrl_d.branch     = branch_d;
    w_ctrl_d.alucontrol = alucontrol_d;
    w_ctrl_d.alusrc     = alusrc_d;
`ifdef IDEX_X0_GUARD_EN
    // Keeps forwarding from ever matching a "write" to x0.
    if (rd_d == 5'd0) begin
      w_ctrl_d.regwrite = 1'b0;
    end
`else
`endif
  end

  load_use_detect u_load_use_detect (
    .i_valid_e     (r_valid),
    .i_resultsrc_e (r_ctrl.resultsrc),
    .i_rd_e        (r_rd),
    .i_rs1_d       (rs1_d),
    .i_rs2_d       (rs2_d),
    .i_flush_e     (flush_e),
    .o_lu          (w_lu),
    .o_stall_fd    (stall_fd)
  );

  assign w_bubble = flush_e | w_lu;

  // On a load-use bubble decode is held upstream, so the same instruction
  // is presented again and captured on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_immext   <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= CTRL_NOP;
      r_valid    <= 1'b0;
    end else if (w_bubble) begin
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_immext   <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= CTRL_NOP;
      r_valid    <= 1'b0;
    end else begin
      r_pc       <= pc_d;
      r_pc_plus4 <= pc_plus4_d;
      r_rd1      <= rd1_d;
      r_rd2      <= rd2_d;
      r_immext   <= immext_d;
      r_rs1      <= rs1_d;
      r_rs2      <= rs2_d;
      r_rd       <= rd_d;
      r_ctrl     <= w_ctrl_d;
      r_valid    <= 1'b1;
    end
  end

  assign pc_e         = r_pc;
  assign pc_plus4_e   = r_pc_plus4;
  assign rd1_e        = r_rd1;
  assign rd2_e        = r_rd2;
  assign immext_e     = r_immext;
  assign rs1_e        = r_rs1;
  assign rs2_e        = r_rs2;
  assign rd_e         = r_rd;
  assign regwrite_e   = r_ctrl.regwrite;
  assign resultsrc_e  = r_ctrl.resultsrc;
  assign memwrite_e   = r_ctrl.memwrite;
  assign jump_e       = r_ctrl.jump;
  assign branch_e     = r_ctrl.branch;
  assign alucontrol_e = r_ctrl.alucontrol;
  assign alusrc_e     = r_ctrl.alusrc;
  assign valid_e      = r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model of the E stage pushes
// expected register contents and stall values; a monitor pops and compares.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic        memwrite;
    logic        jump;
    logic        branch;
    logic [2:0]  aluctl;
    logic        alusrc;
  } stage_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] pc_d, pc_plus4_d, rd1_d, rd2_d, immext_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d, flush_e;
  logic [1:0]  resultsrc_d;
  logic [2:0]  alucontrol_d;
  logic [31:0] pc_e, pc_plus4_e, rd1_e, rd2_e, immext_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e, valid_e, stall_fd;
  logic [1:0]  resultsrc_e;
  logic [2:0]  alucontrol_e;

  stage_t eQ[$];
  logic   stallQ[$];
  stage_t mE;
  logic   lastStall;
  int     testsRun = 0;
  int     testsFailed = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .immext_d(immext_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .memwrite_d(memwrite_d), .jump_d(jump_d),
    .branch_d(branch_d), .alusrc_d(alusrc_d), .resultsrc_d(resultsrc_d),
    .alucontrol_d(alucontrol_d), .flush_e(flush_e),
    .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .immext_e(immext_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .jump_e(jump_e),
    .branch_e(branch_e), .alusrc_e(alusrc_e), .resultsrc_e(resultsrc_e),
    .alucontrol_e(alucontrol_e), .valid_e(valid_e), .stall_fd(stall_fd)
  );

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic stage_t readDut();
    stage_t s;
    s.valid = valid_e;     s.pc = pc_e;        s.pc4 = pc_plus4_e;
    s.rd1 = rd1_e;         s.rd2 = rd2_e;      s.imm = immext_e;
    s.rs1 = rs1_e;         s.rs2 = rs2_e;      s.rd = rd_e;
    s.regwrite = regwrite_e; s.resultsrc = resultsrc_e; s.memwrite = memwrite_e;
    s.jump = jump_e;       s.branch = branch_e; s.aluctl = alucontrol_e;
    s.alusrc = alusrc_e;
    return s;
  endfunction

  task automatic driveD(input stage_t d, input logic fl);
    pc_d = d.pc;   pc_plus4_d = d.pc4; rd1_d = d.rd1; rd2_d = d.rd2;
    immext_d = d.imm; rs1_d = d.rs1; rs2_d = d.rs2; rd_d = d.rd;
    regwrite_d = d.regwrite; resultsrc_d = d.resultsrc; memwrite_d = d.memwrite;
    jump_d = d.jump; branch_d = d.branch; alucontrol_d = d.aluctl;
    alusrc_d = d.alusrc; flush_e = fl;
  endtask

  // What E should hold after capturing decode instruction d.
  function automatic stage_t captureOf(input stage_t d);
    stage_t c = d;
    c.valid = 1'b1;
`ifdef IDEX_X0_GUARD_EN
    if (d.rd == 5'd0) c.regwrite = 1'b0;
`endif
    return c;
  endfunction

  // A real load in E whose nonzero destination is read by decode.
  function automatic logic loadUse(input stage_t e, input stage_t d);
    return e.valid && e.resultsrc == 2'b01 && e.rd != 5'd0 &&
           (e.rd == d.rs1 || e.rd == d.rs2);
  endfunction

  task automatic applyStimulus(input stage_t d, input logic fl);
    logic lu;
    @(negedge clk);
    driveD(d, fl);
    lu = loadUse(mE, d);
    lastStall = lu && !fl;
    stallQ.push_back(lastStall);
    if (fl || lu) mE = '0;
    else          mE = captureOf(d);
    eQ.push_back(mE);
  endtask

  function automatic stage_t randD();
    stage_t d;
    int r;
    d.valid = 1'b0;
    d.pc = $urandom; d.pc4 = d.pc + 32'd4;
    d.rd1 = $urandom; d.rd2 = $urandom; d.imm = $urandom;
    d.rs1 = 5'($urandom_range(0, 3));
    d.rs2 = 5'($urandom_range(0, 3));
    d.rd  = 5'($urandom_range(0, 3));
    d.regwrite = 1'($urandom); d.memwrite = 1'($urandom);
    d.jump = 1'($urandom); d.branch = 1'($urandom);
    d.aluctl = 3'($urandom); d.alusrc = 1'($urandom);
    r = $urandom_range(0, 3);
    d.resultsrc = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b01;
    return d;
  endfunction

  function automatic stage_t mkD(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [1:0] src,
                                 input logic regwrite, input logic [31:0] imm);
    stage_t d;
    d = '0;
    d.pc = 32'h100; d.pc4 = 32'h104; d.rd1 = 32'h11; d.rd2 = 32'h22;
    d.imm = imm; d.rs1 = rs1; d.rs2 = rs2; d.rd = rd;
    d.resultsrc = src; d.regwrite = regwrite; d.aluctl = 3'd2;
    return d;
  endfunction

  // Monitor: stall is sampled mid-low-phase, E contents just after the edge.
  initial begin
    logic   expStall;
    stage_t expE;
    forever begin
      @(negedge clk);
      #2;
      if (stallQ.size() > 0) begin
        expStall = stallQ.pop_front();
        checkOutput("stall_fd", 256'(stall_fd), 256'(expStall));
      end
      @(posedge clk);
      #1;
      if (eQ.size() > 0) begin
        expE = eQ.pop_front();
        checkOutput("e_regs", 256'(readDut()), 256'(expE));
      end
    end
  end

  initial begin
    stage_t ld, dep, d;
    logic   fl;
    int     n;

    rst_n = 1'b0;
    mE = '0;
    lastStall = 1'b0;
    ld = '0;
    ld.pc = 32'h40; ld.pc4 = 32'h44; ld.rd1 = 32'hA; ld.rd2 = 32'hB; ld.imm = 32'hC;
    ld.rs1 = 5'd7; ld.rs2 = 5'd9; ld.rd = 5'd7; ld.regwrite = 1'b1;
    ld.resultsrc = 2'b01; ld.memwrite = 1'b1; ld.jump = 1'b1; ld.branch = 1'b1;
    ld.aluctl = 3'd5; ld.alusrc = 1'b1;
    driveD(ld, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_idle_e", 256'(readDut()), 256'(0));

    // Release, capture a load that depends on itself, then reset mid-cycle.
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("first_capture", 256'(readDut()), 256'(captureOf(ld)));
    checkOutput("pre_reset_stall", 256'(stall_fd), 256'(1));
    #2; rst_n = 1'b0;
    #1;
    checkOutput("async_reset_e", 256'(readDut()), 256'(0));
    checkOutput("async_reset_stall", 256'(stall_fd), 256'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset_capture", 256'(readDut()), 256'(captureOf(ld)));
    mE = captureOf(ld);

    // Directed scenarios
    applyStimulus(mkD(5'd3, 5'd4, 5'd5, 2'b00, 1'b1, 32'h10), 1'b0);
    applyStimulus(mkD(5'd1, 5'd2, 5'd7, 2'b01, 1'b1, 32'h0), 1'b0);
    dep = mkD(5'd1, 5'd7, 5'd8, 2'b00, 1'b1, 32'h20);
    applyStimulus(dep, 1'b0);
    applyStimulus(dep, 1'b0);
    applyStimulus(mkD(5'd1, 5'd2, 5'd0, 2'b01, 1'b1, 32'h0), 1'b0);
    applyStimulus(mkD(5'd0, 5'd0, 5'd6, 2'b00, 1'b1, 32'h30), 1'b0);
    applyStimulus(mkD(5'd1, 5'd2, 5'd7, 2'b01, 1'b1, 32'h0), 1'b0);
    applyStimulus(dep, 1'b1);
    applyStimulus(mkD(5'd1, 5'd2, 5'd0, 2'b00, 1'b1, 32'h40), 1'b0);

    // Randomized traffic; a stalled decode instruction is re-presented.
    d = randD();
    for (n = 0; n < 400; n++) begin
      if (!lastStall) d = randD();
      fl = ($urandom_range(0, 7) == 0);
      applyStimulus(d, fl);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_drained", 256'(eQ.size() + stallQ.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
